// File: rtl/uart_rx_sampler_if.sv
// Byte-stream bundle between the serial receiver and its consumer.
//   rx_serial  raw serial line into the receiver (idle high, asynchronous)
//   rx_dat     last good received byte
//   rx_stb     one-cycle pulse: rx_dat newly valid
//   rx_err     one-cycle pulse: framing error
//   rx_active  receiver busy with a frame (or waiting out a line break)
// master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_sampler_if;
  logic       rx_serial;
  logic [7:0] rx_dat;
  logic       rx_stb;
  logic       rx_err;
  logic       rx_active;

  modport master (
    input  rx_serial,
    output rx_dat,
    output rx_stb,
    output rx_err,
    output rx_active
  );

  modport slave (
    output rx_serial,
    input  rx_dat,
    input  rx_stb,
    input  rx_err,
    input  rx_active
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// 8N1 LSB-first serial receiver. The raw line is synchronised (2 flops plus
// one extra stage, rs_r), the start bit is confirmed by a mid-symbol vote, and
// every bit is taken as the 3-tap majority of rs_r at counter mid-1/mid/mid+1.
// A good stop bit loads rx_dat and pulses rx_stb; a low stop bit pulses rx_err
// and parks the receiver until the line returns high.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   bus  uart_rx_sampler_if.master (rx_serial in; rx_dat/rx_stb/rx_err/rx_active out)
// Parameters:
//   sym_cnt  clocks per symbol (>= 8)
//   SCW      symbol counter width, 2**SCW > sym_cnt
module uart_rx_sampler #(
  parameter int sym_cnt = 2500,
  parameter int SCW     = 12
) (
  input  logic               clk,
  input  logic               rst,
  uart_rx_sampler_if.master  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  localparam logic [SCW-1:0] MID_M1   = SCW'(sym_cnt / 2 - 1);
  localparam logic [SCW-1:0] MID      = SCW'(sym_cnt / 2);
  localparam logic [SCW-1:0] MID_P1   = SCW'(sym_cnt / 2 + 1);
  localparam logic [SCW-1:0] SYM_LAST = SCW'(sym_cnt - 1);

  // 2-of-3 majority used for every bit decision
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic           sync1_r;
  logic           sync2_r;
  logic           rs_r;
  logic [2:0]     state_r;
  logic [SCW-1:0] cnt_r;
  logic [2:0]     bit_idx_r;
  logic [7:0]     shift_r;
  logic           samp_lo_r;
  logic           samp_mid_r;
  logic [7:0]     rx_dat_r;
  logic           rx_stb_r;
  logic           rx_err_r;
  logic           rx_active_r;
  logic           vote_s;
  logic           cnt_end_s;
  logic [SCW-1:0] cnt_inc_s;

  // Third tap is the live rs_r at mid+1, so the vote is ready on that cycle.
  assign vote_s    = maj3(samp_lo_r, samp_mid_r, rs_r);
  assign cnt_end_s = (cnt_r == SYM_LAST);
  assign cnt_inc_s = cnt_end_s ? {SCW{1'b0}} : cnt_r + {{(SCW-1){1'b0}}, 1'b1};

  // Line synchroniser; flops preset to 1 so reset looks like an idle line
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      rs_r    <= 1'b1;
    end else begin
      sync1_r <= bus.rx_serial;
      sync2_r <= sync1_r;
      rs_r    <= sync2_r;
    end
  end

  // Capture the first two vote taps of the current symbol
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_lo_r  <= 1'b1;
      samp_mid_r <= 1'b1;
    end else if (cnt_r == MID_M1) begin
      samp_lo_r  <= rs_r;
    end else if (cnt_r == MID) begin
      samp_mid_r <= rs_r;
    end else begin
      samp_lo_r  <= samp_lo_r;
      samp_mid_r <= samp_mid_r;
    end
  end

  // Frame state machine, symbol counter, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {SCW{1'b0}};
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      rx_dat_r    <= 8'h00;
      rx_stb_r    <= 1'b0;
      rx_err_r    <= 1'b0;
      rx_active_r <= 1'b0;
    end else begin
      rx_stb_r <= 1'b0;
      rx_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r       <= {SCW{1'b0}};
          bit_idx_r   <= 3'd0;
          rx_active_r <= 1'b0;
          if (!rs_r) begin
            state_r <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          cnt_r <= cnt_inc_s;
          if (cnt_r == MID_P1) begin
            if (vote_s) begin
              // start bit did not hold low: treat as a glitch
              state_r <= ST_IDLE;
              cnt_r   <= {SCW{1'b0}};
            end else begin
              rx_active_r <= 1'b1;
            end
          end else if (cnt_end_s) begin
            state_r <= ST_DATA;
          end else begin
            state_r <= ST_START;
          end
        end
        ST_DATA: begin
          cnt_r <= cnt_inc_s;
          if (cnt_r == MID_P1) begin
            shift_r <= {vote_s, shift_r[7:1]};
          end else begin
            shift_r <= shift_r;
          end
          if (cnt_end_s) begin
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed
          if (cnt_r == MID_P1) begin
            cnt_r <= {SCW{1'b0}};
            if (vote_s) begin
              rx_dat_r <= shift_r;
              rx_stb_r <= 1'b1;
              state_r  <= ST_IDLE;
            end else begin
              rx_err_r <= 1'b1;
              state_r  <= ST_BREAK;
            end
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        ST_BREAK: begin
          cnt_r <= {SCW{1'b0}};
          if (rs_r) begin
            state_r     <= ST_IDLE;
            rx_active_r <= 1'b0;
          end else begin
            state_r <= ST_BREAK;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= {SCW{1'b0}};
          rx_active_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_dat    = rx_dat_r;
  assign bus.rx_stb    = rx_stb_r;
  assign bus.rx_err    = rx_err_r;
  assign bus.rx_active = rx_active_r;

endmodule
